// File: rtl/shared_link_arbiter.sv
// -----------------------------------------------------------------------------
// shared_link_arbiter
//
// Round-robin arbiter that shares one registered W-bit link among N
// requesters. A requester raises req, receives a one-hot grant, and streams
// data_in onto the link (one word per cycle) for as long as it keeps req high.
// Dropping req releases the link; at least one IDLE cycle separates grants.
// The round-robin pointer moves to the index after the releasing owner.
//
// Optional feature (compile-time macro SHARED_LINK_TIMEOUT_EN):
//   A hold counter limits each grant to MAX_HOLD transfer cycles, after which
//   the link is released exactly as if req had dropped. Without the macro no
//   counter is built and MAX_HOLD has no effect.
//
// Parameters:
//   N        number of requesters (2..8)
//   W        data width of each requester and of the link
//   MAX_HOLD maximum consecutive transfers per grant (timeout build only)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   N    level-sensitive request per requester
//   data_in    in   N*W  requester i drives bits [i*W +: W]
//   grant      out  N    registered one-hot grant
//   link_data  out  W    registered link data
//   link_valid out  1    link_data holds a transfer this cycle
//   busy       out  1    a grant is active
// -----------------------------------------------------------------------------
module shared_link_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   grant,
    output logic [W-1:0]   link_data,
    output logic           link_valid,
    output logic           busy
);

    localparam int PTR_W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]   link_data_q, link_data_d;
    logic           link_valid_q, link_valid_d;

`ifdef SHARED_LINK_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    logic [W-1:0]   sel_data;
    logic           owner_req;
    logic           release_c;

    // First requesting index found when scanning upward from p, wrapping.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0]     r,
                                             input logic [PTR_W-1:0] p);
        logic [N-1:0] pick;
        logic         found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && r[j] && (j == (int'(p) + k) % N)) begin
                    pick[j] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    // Pointer value that follows the current one-hot owner.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [N-1:0] g);
        logic [PTR_W-1:0] np;
        np = '0;
        for (int j = 0; j < N; j++) begin
            if (g[j]) begin
                np = PTR_W'((j + 1) % N);
            end
        end
        return np;
    endfunction

    // One-hot grant makes an AND-OR mux sufficient.
    always_comb begin
        sel_data = '0;
        for (int j = 0; j < N; j++) begin
            if (grant_q[j]) begin
                sel_data = sel_data | data_in[j*W +: W];
            end
        end
    end

    assign owner_req = |(req & grant_q);

`ifdef SHARED_LINK_TIMEOUT_EN
    assign release_c = !owner_req || (hold_q == HOLD_W'(MAX_HOLD));
`else
    assign release_c = !owner_req;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        link_data_d  = link_data_q;
        link_valid_d = 1'b0;
`ifdef SHARED_LINK_TIMEOUT_EN
        hold_d       = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = rr_pick(req, ptr_q);
                    state_d = GRANT;
`ifdef SHARED_LINK_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (release_c) begin
                    grant_d = '0;
                    ptr_d   = next_ptr(grant_q);
                    state_d = IDLE;
`ifdef SHARED_LINK_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    link_data_d  = sel_data;
                    link_valid_d = 1'b1;
`ifdef SHARED_LINK_TIMEOUT_EN
                    hold_d       = hold_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
`ifdef SHARED_LINK_TIMEOUT_EN
            hold_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            link_data_q  <= link_data_d;
            link_valid_q <= link_valid_d;
`ifdef SHARED_LINK_TIMEOUT_EN
            hold_q       <= hold_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign link_data  = link_data_q;
    assign link_valid = link_valid_q;
    assign busy       = (state_q == GRANT);

endmodule

// File: tb/tb_shared_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_link_arbiter
//
// Drives shared_link_arbiter (N=4, W=8, MAX_HOLD=4) with directed scenarios
// and randomized request patterns, comparing every cycle against an
// integer-level reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_shared_link_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic [W-1:0]   link_data;
    logic           link_valid;
    logic           busy;

    int n_tests;
    int n_fail;

    // reference model: owner index (-1 = none), pointer, transfer count
    int           m_owner;
    int           m_ptr;
    int           m_hold;
    logic [W-1:0] m_data;
    logic         m_valid;

    int           gq[$];
    logic [N-1:0] prev_grant;

    shared_link_arbiter #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .link_data  (link_data),
        .link_valid (link_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_data  = '0;
        m_valid = 1'b0;
    endtask

    // One clock edge of the arbitration rules, applied to the sampled inputs.
    task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] d);
        bit timeout;
        if (m_owner < 0) begin
            m_valid = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r[c]) begin
                    m_owner = c;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
`ifdef SHARED_LINK_TIMEOUT_EN
            timeout = (m_hold == MH);
`else
            timeout = 1'b0;
`endif
            if (!r[m_owner] || timeout) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_valid = 1'b0;
                m_hold  = 0;
            end else begin
                m_data  = d[m_owner*W +: W];
                m_valid = 1'b1;
                m_hold++;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic compare_all();
        chk("grant",      32'(grant),      32'(exp_grant()));
        chk("link_valid", 32'(link_valid), 32'(m_valid));
        chk("busy",       32'(busy),       32'(m_owner >= 0));
        chk("link_data",  32'(link_data),  32'(m_data));
        chk("onehot0",    32'($onehot0(grant)), 32'd1);
        if (grant != '0 && prev_grant == '0) begin
            for (int j = 0; j < N; j++) if (grant[j]) gq.push_back(j);
        end
        prev_grant = grant;
    endtask

    // Entered at a falling edge: drive inputs, advance model, check at next fall.
    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d);
        req     = r;
        data_in = d;
        model_edge(r, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input logic [N-1:0] r, input int cycles);
        for (int c = 0; c < cycles; c++) step(r, {$urandom, $urandom});
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_grant",      32'(grant),      32'd0);
        chk("rst_link_valid", 32'(link_valid), 32'd0);
        chk("rst_link_data",  32'(link_data),  32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        model_reset();
        req = '0;
        prev_grant = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req        = '0;
        data_in    = '0;
        prev_grant = '0;
        model_reset();

        // reset state after a clock edge under reset
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // single request from requester 2
        step(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_busy",  32'(busy),  32'd1);
        step(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        chk("single_data",  32'(link_data),  32'hA5);
        chk("single_valid", 32'(link_valid), 32'd1);
        chk("single_busy2", 32'(busy),       32'd1);

        // fairness: all request, each owner drops after three transfers
        do_reset();
        gq.delete();
        for (int c = 0; c < 22; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_hold == 3) r[m_owner] = 1'b0;
            step(r, {$urandom, $urandom});
        end
        chk("fair_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("fair_order", 32'(gq[i]), 32'(i % N));

        // pointer wrap
        do_reset();
        run(4'b1000, 2);
        run(4'b0000, 1);
        step(4'b1001, {$urandom, $urandom});
        chk("wrap_to0", 32'(grant), 32'h1);
        run(4'b1001, 1);
        run(4'b1000, 1);
        run(4'b1000, 1);
        step(4'b1001, {$urandom, $urandom});
        chk("wrap_to3", 32'(grant), 32'h8);
        run(4'b0000, 2);

        // no preemption
        do_reset();
        run(4'b0010, 2);
        run(4'b0011, 4);
        chk("nopre_hold", 32'(grant), 32'h2);
        run(4'b0001, 1);
        chk("nopre_idle", 32'(grant), 32'h0);
        run(4'b0001, 1);
        chk("nopre_next", 32'(grant), 32'h1);

        // reset mid-stream, then requester 2 from a cleared pointer
        run(4'b0001, 3);
        chk("mid_valid", 32'(link_valid), 32'd1);
        do_reset();
        step(4'b0100, {$urandom, $urandom});
        chk("post_rst_grant", 32'(grant), 32'h4);

        // continuous requests from 0 and 1 (timeout behaviour depends on build)
        do_reset();
        gq.delete();
        run(4'b0011, 15);
`ifdef SHARED_LINK_TIMEOUT_EN
        chk("to_count", 32'(gq.size()), 32'd3);
        if (gq.size() == 3) begin
            chk("to_first",  32'(gq[0]), 32'd0);
            chk("to_second", 32'(gq[1]), 32'd1);
            chk("to_third",  32'(gq[2]), 32'd0);
        end
`else
        chk("hold_count", 32'(gq.size()), 32'd1);
        chk("hold_owner", 32'(grant),     32'h1);
`endif

        // randomized request streams
        do_reset();
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
            step(r, {$urandom, $urandom});
            if (c == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_link_arbiter.md
# shared_link_arbiter

Round-robin arbiter that shares one W-bit point-to-point link (a registered "cable") among N requesters. Each requester raises a request, receives a one-hot grant, and drives data onto the link for as long as it holds the request. The block sits between the lab's source modules and the single shared output path, sequencing ownership of that path and registering the selected data onto it.

## Interface
- N, default 4: number of requesters (2..8).
- W, default 8: data width of each requester and of the link.
- MAX_HOLD, default 16: maximum consecutive transfer cycles per grant (only used with SHARED_LINK_TIMEOUT_EN).

- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request per requester, level-sensitive.
- data_in  input  N*W  requester data; requester i occupies bits [i*W +: W].
- grant  output  N  one-hot grant, registered.
- link_data  output  W  registered link data.
- link_valid  output  1  link_data holds a transfer this cycle.
- busy  output  1  high while a grant is active.

## Operation
- FSM states: IDLE, GRANT.
- IDLE: when any req bit is high, select the winner by round-robin starting at index ptr, ascending and wrapping N-1 -> 0. Load grant with the winner (one-hot) and move to GRANT. With no requests, stay in IDLE with grant = 0.
- GRANT, when req[g] is high for granted index g: transfer cycle. Register link_data <= data_in[g] and link_valid <= 1.
- GRANT, when req[g] is low: release. Set grant <= 0, link_valid <= 0, ptr <= (g+1) mod N, and move to IDLE.
- Requests from non-granted requesters are ignored during GRANT. There is no preemption.
- ptr updates only on release. The winner is chosen only in IDLE.
- busy = (state == GRANT).
- At most one grant bit is high in any cycle.
- Reset (asserted at any time, including mid-transfer): state IDLE, grant = 0, link_data = 0, link_valid = 0, busy = 0, ptr = 0, hold counter = 0. Outputs clear asynchronously.

## Timing
- Request-to-grant latency: req sampled high in IDLE at edge k, so grant is visible after edge k.
- Grant-to-data latency: data_in[g] sampled at edge k+1 appears on link_data after edge k+1, with link_valid high.
- Release: req[g] low sampled at edge m, so grant and link_valid are low after edge m. At least one IDLE cycle always separates consecutive grants. The same requester cannot be regranted sooner than edge m+1.
- Back-to-back stream: one transfer per cycle while req[g] stays high.
- Simultaneous requests in IDLE: the round-robin order from ptr decides. Requester 0 wins the first arbitration after reset.

## Configuration
- SHARED_LINK_TIMEOUT_EN defined:
  - A hold counter (width clog2(MAX_HOLD+1)) counts transfer cycles in GRANT.
  - When the counter reaches MAX_HOLD, the next edge forces a release exactly as if req[g] had dropped: grant cleared, ptr advanced, counter cleared, state IDLE.
  - If only the same requester is still requesting, it is regranted after the single IDLE cycle.
- SHARED_LINK_TIMEOUT_EN not defined: no counter is built, MAX_HOLD is unused, and a requester holds the link indefinitely.

## Test plan
- Reset and single request: after reset, req=4'b0100 and data_in[2]=8'hA5 -> grant=4'b0100 one cycle later, link_data=8'hA5 with link_valid=1 the following cycle, busy=1 throughout the grant.
- Simultaneous requests and fairness: req=4'b1111 held, each owner dropping req after 3 transfers then re-raising -> grants appear in order 0,1,2,3,0, each grant separated by one IDLE cycle.
- Pointer wrap: last grant to requester 3, then req=4'b1001 -> requester 0 wins. Last grant to requester 0, then req=4'b1001 -> requester 3 wins.
- No preemption: requester 1 granted, req[0] raised mid-grant -> grant stays 4'b0010 until req[1] drops, then requester 0 is granted after one IDLE cycle.
- Reset mid-operation: rst_n pulled low during a stream with link_valid=1 -> grant=0, link_valid=0, link_data=8'h00 immediately without waiting for a clock edge. After release, req=4'b0100 -> requester 2 is granted (ptr=0, lowest requesting index from 0 is 2).
- With SHARED_LINK_TIMEOUT_EN and MAX_HOLD=4: req=4'b0011 held continuously -> requester 0 makes exactly 4 transfers, one IDLE cycle, requester 1 makes 4 transfers, then requester 0 again. Without the macro: requester 0 keeps the grant indefinitely.
